// File: rtl/mem_port_arbiter.sv
// Three-requester round-robin arbiter for a single-port memory. It grants whole
// bursts and forwards read data back to the requester that owns the port.
module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [2:0]            wr,
  input  logic [3*ADDR_W-1:0]   reqAddr,
  input  logic [3*LEN_W-1:0]    reqLen,
  input  logic [3*DATA_W-1:0]   wData,
  input  logic [DATA_W-1:0]     memRData,
  output logic [ADDR_W-1:0]     memAddress,
  output logic                  memWe,
  output logic                  memRe,
  output logic [DATA_W-1:0]     memWData,
  output logic [2:0]            grant,
  output logic [2:0]            rdValid,
  output logic [DATA_W-1:0]     rdData,
  output logic [2:0]            done,
  output logic                  busy,
  output logic [1:0]            dbgState
);

  // Handshake: req is a level, sampled only in IDLE. Once granted, the owner
  // keeps grant until its done pulse, supplies wData live for each write beat,
  // and takes rdData whenever its rdValid bit is high. There is no back-pressure.

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        r_owner;
  logic [1:0]        r_last;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_lastBeat;
  logic [LEN_W-1:0]  r_beatCnt;
  logic              r_wr;
  logic              r_rdPend;

  logic [ADDR_W-1:0] w_addrArr [3];
  logic [LEN_W-1:0]  w_lenArr  [3];
  logic [DATA_W-1:0] w_wdArr   [3];
  logic [1:0]        w_c0;
  logic [1:0]        w_c1;
  logic [1:0]        w_c2;
  logic [1:0]        w_winner;
  logic              w_hit;
  logic [2:0]        w_ownerOh;
  logic [ADDR_W-1:0] w_beatAddr;
  logic              w_inBurst;
  logic              w_inDone;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_addrArr[i] = reqAddr[i*ADDR_W +: ADDR_W];
      w_lenArr[i]  = reqLen[i*LEN_W +: LEN_W];
      w_wdArr[i]   = wData[i*DATA_W +: DATA_W];
    end
  end

  // Search order starts just after the last served requester; later
  // assignments override earlier ones, so the first hit in order wins.
  always_comb begin
    w_c0     = next_idx(r_last);
    w_c1     = next_idx(w_c0);
    w_c2     = next_idx(w_c1);
    w_hit    = |req;
    w_winner = w_c0;
    if (req[w_c2]) w_winner = w_c2;
    if (req[w_c1]) w_winner = w_c1;
    if (req[w_c0]) w_winner = w_c0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_owner    <= 2'd0;
      r_last     <= 2'd2;
      r_base     <= '0;
      r_lastBeat <= '0;
      r_beatCnt  <= '0;
      r_wr       <= 1'b0;
      r_rdPend   <= 1'b0;
    end else begin
      r_rdPend <= (r_state == S_BURST) && !r_wr;
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_state   <= S_BURST;
            r_owner   <= w_winner;
            r_base    <= w_addrArr[w_winner];
            r_wr      <= wr[w_winner];
            r_beatCnt <= '0;
            // A zero length still moves one beat.
            r_lastBeat <= (w_lenArr[w_winner] == '0) ? '0
                                                     : w_lenArr[w_winner] - LEN_W'(1);
          end
        end
        S_BURST: begin
          r_beatCnt <= r_beatCnt + LEN_W'(1);
          if (r_beatCnt == r_lastBeat) r_state <= S_DONE;
        end
        S_DONE: begin
          r_last  <= r_owner;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_inBurst  = (r_state == S_BURST);
  assign w_inDone   = (r_state == S_DONE);
  assign w_ownerOh  = 3'b001 << r_owner;
  assign w_beatAddr = r_base + ADDR_W'(r_beatCnt);

  assign memAddress = w_inBurst ? w_beatAddr : '0;
  assign memWe      = w_inBurst && r_wr;
  assign memRe      = w_inBurst && !r_wr;
  assign memWData   = w_inBurst ? w_wdArr[r_owner] : '0;
  assign grant      = (w_inBurst || w_inDone) ? w_ownerOh : 3'b000;
  assign done       = w_inDone ? w_ownerOh : 3'b000;
  assign busy       = (r_state != S_IDLE);
  // Read data trails its address by one cycle, so the last one lands in DONE.
  assign rdValid    = r_rdPend ? w_ownerOh : 3'b000;
  assign rdData     = r_rdPend ? memRData : '0;
  assign dbgState   = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a burst-level schedule model predicts every
// output cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int LW = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b0;
  logic [2:0]        req = '0;
  logic [2:0]        wr = '0;
  logic [3*AW-1:0]   reqAddr = '0;
  logic [3*LW-1:0]   reqLen = '0;
  logic [3*DW-1:0]   wData = '0;
  logic [DW-1:0]     memRData = '0;
  logic [AW-1:0]     memAddress;
  logic              memWe, memRe;
  logic [DW-1:0]     memWData;
  logic [2:0]        grant, rdValid, done;
  logic [DW-1:0]     rdData;
  logic              busy;
  logic [1:0]        dbgState;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .reqAddr(reqAddr), .reqLen(reqLen),
    .wData(wData), .memRData(memRData), .memAddress(memAddress), .memWe(memWe),
    .memRe(memRe), .memWData(memWData), .grant(grant), .rdValid(rdValid),
    .rdData(rdData), .done(done), .busy(busy), .dbgState(dbgState)
  );

  // Memory seen by the DUT, and the model's own copy of it.
  logic [DW-1:0] mem     [1<<AW];
  logic [DW-1:0] ref_mem [1<<AW];
  always @(posedge clk) begin
    if (memWe) mem[memAddress] <= memWData;
    if (memRe) memRData <= mem[memAddress];
  end

  // ---------------- stimulus shadows ----------------
  logic          s_rst;
  logic [2:0]    s_req, s_wr;
  logic [AW-1:0] s_addr [3];
  logic [LW-1:0] s_len  [3];
  logic [DW-1:0] s_wd   [3];

  // ---------------- model / scoreboard ----------------
  typedef struct {
    logic [2:0]    grant;
    logic          beat;
    logic [AW-1:0] addr;
    logic          we;
    logic          re;
    logic [2:0]    rdv;
    logic [DW-1:0] rdd;
    logic [2:0]    done;
    int            own;
  } exp_t;

  exp_t exp_q[$];
  int   m_last;
  int   errors = 0;
  int   checks = 0;

  // Observation logs for directed checks.
  logic [31:0] grant_log[$];
  logic [31:0] addr_log[$];
  logic [31:0] done_log[$];
  logic [31:0] gap_log[$];
  int done_cnt, busy_cnt, rdv_cnt, cyc, last_done_cyc;
  logic [2:0] prev_grant;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_logs();
    grant_log.delete(); addr_log.delete(); done_log.delete(); gap_log.delete();
    done_cnt = 0; busy_cnt = 0; rdv_cnt = 0; last_done_cyc = cyc;
  endtask

  // Winner selection and full burst schedule from the request rules.
  task automatic push_burst();
    int w, el;
    exp_t r;
    w = -1;
    for (int k = 1; k <= 3; k++)
      if (w < 0 && s_req[(m_last + k) % 3]) w = (m_last + k) % 3;
    el = (s_len[w] == 0) ? 1 : int'(s_len[w]);
    for (int k = 0; k <= el; k++) begin
      r.grant = 3'(1 << w);
      r.own   = w;
      r.beat  = (k < el);
      r.addr  = r.beat ? AW'(int'(s_addr[w]) + k) : '0;
      r.we    = r.beat && s_wr[w];
      r.re    = r.beat && !s_wr[w];
      r.rdv   = (k > 0 && !s_wr[w]) ? 3'(1 << w) : 3'b000;
      r.rdd   = (k > 0) ? ref_mem[AW'(int'(s_addr[w]) + k - 1)] : '0;
      r.done  = (k == el) ? 3'(1 << w) : 3'b000;
      exp_q.push_back(r);
    end
    m_last = w;
  endtask

  // One cycle: drive at negedge, check the settled outputs, advance the model.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    rst = s_rst;
    req = s_req;
    wr  = s_wr;
    for (int i = 0; i < 3; i++) begin
      reqAddr[i*AW +: AW] = s_addr[i];
      reqLen[i*LW +: LW]  = s_len[i];
      wData[i*DW +: DW]   = s_wd[i];
    end
    if (!s_rst) begin
      exp_q.delete();
      m_last = 2;
    end
    #1;
    if (exp_q.size() > 0) e = exp_q[0];
    else begin
      e.grant = '0; e.beat = 1'b0; e.addr = '0; e.we = 1'b0; e.re = 1'b0;
      e.rdv = '0; e.rdd = '0; e.done = '0; e.own = 0;
    end
    chk("grant",      32'(grant),      32'(e.grant));
    chk("busy",       32'(busy),       32'(e.grant != 0));
    chk("memWe",      32'(memWe),      32'(e.we));
    chk("memRe",      32'(memRe),      32'(e.re));
    chk("memAddress", 32'(memAddress), 32'(e.addr));
    chk("memWData",   32'(memWData),   e.beat ? 32'(s_wd[e.own]) : 32'h0);
    chk("rdValid",    32'(rdValid),    32'(e.rdv));
    chk("done",       32'(done),       32'(e.done));
    if (e.rdv != 0) chk("rdData", 32'(rdData), 32'(e.rdd));

    cyc++;
    if (grant != 0 && prev_grant == 0) begin
      grant_log.push_back(32'(grant));
      gap_log.push_back(32'(cyc - last_done_cyc));
    end
    if (memWe || memRe) addr_log.push_back(32'(memAddress));
    if (done != 0) begin
      done_cnt++; done_log.push_back(32'(done)); last_done_cyc = cyc;
    end
    if (busy) busy_cnt++;
    if (rdValid != 0) rdv_cnt++;
    prev_grant = grant;

    if (s_rst) begin
      if (exp_q.size() > 0) begin
        if (e.we) ref_mem[e.addr] = s_wd[e.own];
        void'(exp_q.pop_front());
      end else if (s_req != 0) begin
        push_burst();
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    s_rst = 1'b0; s_req = '0; s_wr = '0;
    tick(); tick();
    s_rst = 1'b1;
    tick();
  endtask

  task automatic set_req(input int i, input int addr, input int len, input logic w);
    s_addr[i] = AW'(addr); s_len[i] = LW'(len); s_wr[i] = w;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    cyc = 0; prev_grant = '0; m_last = 2;
    for (int a = 0; a < (1 << AW); a++) begin
      mem[a] = DW'($urandom);
      ref_mem[a] = mem[a];
    end
    s_rst = 1'b0; s_req = '0; s_wr = '0;
    for (int i = 0; i < 3; i++) begin s_addr[i] = '0; s_len[i] = '0; s_wd[i] = '0; end

    // Reset state
    tick();
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_grant", 32'(grant), 32'h0);
    do_reset();

    // Single read of four beats
    set_req(0, 71, 4, 1'b0);
    s_req = 3'b001;
    clear_logs();
    tick();
    s_req = 3'b000;
    idle(8);
    for (int k = 0; k < 4; k++) chk("read_addr", q_at(addr_log, k), 32'(71 + k));
    chk("read_addr_cnt", 32'(addr_log.size()), 32'd4);
    chk("read_rdv_cnt", 32'(rdv_cnt), 32'd4);
    chk("read_done_cnt", 32'(done_cnt), 32'd1);
    chk("read_busy_cycles", 32'(busy_cnt), 32'd5);

    // Round robin with all requesters held
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 100 * i + 5, 2, 1'b0);
    s_req = 3'b111;
    clear_logs();
    idle(17);
    s_req = 3'b000;
    idle(6);
    chk("rr_grant0", q_at(grant_log, 0), 32'h1);
    chk("rr_grant1", q_at(grant_log, 1), 32'h2);
    chk("rr_grant2", q_at(grant_log, 2), 32'h4);
    chk("rr_grant3", q_at(grant_log, 3), 32'h1);
    for (int k = 1; k < 4; k++) chk("rr_gap", q_at(gap_log, k), 32'd2);

    // Write burst from requester 2
    do_reset();
    set_req(2, 332, 3, 1'b1);
    s_req = 3'b100;
    clear_logs();
    tick();
    s_req = 3'b000;
    s_wd[2] = 8'hA1; tick();
    s_wd[2] = 8'hB2; tick();
    s_wd[2] = 8'hC3; tick();
    idle(4);
    chk("wr_mem332", 32'(mem[332]), 32'hA1);
    chk("wr_mem333", 32'(mem[333]), 32'hB2);
    chk("wr_mem334", 32'(mem[334]), 32'hC3);
    chk("wr_no_rdv", 32'(rdv_cnt), 32'd0);

    // Address wrap and zero length
    do_reset();
    set_req(0, 1022, 4, 1'b0);
    s_req = 3'b001;
    clear_logs();
    tick();
    s_req = 3'b000;
    idle(7);
    chk("wrap_a0", q_at(addr_log, 0), 32'd1022);
    chk("wrap_a1", q_at(addr_log, 1), 32'd1023);
    chk("wrap_a2", q_at(addr_log, 2), 32'd0);
    chk("wrap_a3", q_at(addr_log, 3), 32'd1);
    set_req(1, 5, 0, 1'b0);
    s_req = 3'b010;
    clear_logs();
    tick();
    s_req = 3'b000;
    idle(5);
    chk("len0_beats", 32'(addr_log.size()), 32'd1);
    chk("len0_done", 32'(done_cnt), 32'd1);

    // Reset during beat 2 of a five-beat burst
    do_reset();
    set_req(0, 100, 5, 1'b0);
    s_req = 3'b001;
    clear_logs();
    tick();
    s_req = 3'b000;
    tick(); tick();
    s_rst = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_addr", 32'(memAddress), 32'h0);
    chk("abort_re", 32'(memRe), 32'h0);
    tick();
    s_rst = 1'b1;
    set_req(1, 40, 1, 1'b0);
    s_req = 3'b010;
    tick();
    s_req = 3'b000;
    idle(5);
    chk("abort_done_cnt", 32'(done_cnt), 32'd1);
    chk("abort_first_done", q_at(done_log, 0), 32'h2);
    chk("abort_regrant", q_at(grant_log, 1), 32'h2);

    // Request churn during a burst
    do_reset();
    set_req(0, 10, 4, 1'b0);
    set_req(1, 20, 2, 1'b1);
    s_req = 3'b001;
    clear_logs();
    tick();
    s_req = 3'b000; tick();
    s_req = 3'b010;
    idle(5);
    s_req = 3'b000;
    idle(6);
    chk("churn_g0", q_at(grant_log, 0), 32'h1);
    chk("churn_g1", q_at(grant_log, 1), 32'h2);
    chk("churn_ngrant", 32'(grant_log.size()), 32'd2);
    chk("churn_done0", q_at(done_log, 0), 32'h1);
    chk("churn_gap", q_at(gap_log, 1), 32'd2);
    for (int k = 0; k < 4; k++) chk("churn_addr", q_at(addr_log, k), 32'(10 + k));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      s_rst = ($urandom_range(0, 399) != 0);
      s_req = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      s_wr  = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        s_addr[i] = AW'($urandom_range(0, (1 << AW) - 1));
        s_len[i]  = ($urandom_range(0, 9) == 0) ? LW'($urandom_range(0, 63))
                                                : LW'($urandom_range(0, 6));
        s_wd[i]   = DW'($urandom);
      end
      tick();
    end
    s_rst = 1'b1; s_req = '0;
    idle(70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 10, memory address width; DATA_W, default 8, data width; LEN_W, default 6, burst length width.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req  input  3  per-requester burst request; index 0 = filter loader, 1 = buffer loader, 2 = result writer.
REQ-005 wr  input  3  per-requester direction; 1 = write burst, 0 = read burst.
REQ-006 reqAddr  input  3*ADDR_W  per-requester burst base address; requester i uses slice i.
REQ-007 reqLen  input  3*LEN_W  per-requester beat count.
REQ-008 wData  input  3*DATA_W  per-requester write data for the current beat.
REQ-009 memRData  input  DATA_W  memory read data, valid one cycle after the read address.
REQ-010 memAddress  output  ADDR_W  memory address.
REQ-011 memWe  output  1  memory write strobe.
REQ-012 memRe  output  1  memory read strobe.
REQ-013 memWData  output  DATA_W  memory write data.
REQ-014 grant  output  3  one-hot owner of the port; 0 when no owner.
REQ-015 rdValid  output  3  one-hot; rdData is valid for the indicated requester.
REQ-016 rdData  output  DATA_W  memRData forwarded to the owning requester.
REQ-017 done  output  3  one-cycle pulse marking completion of that requester's burst.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, BURST, DONE.
REQ-020 IDLE: req SHALL be sampled only in this state; at least one req bit high SHALL cause a transition to BURST on the next edge.
REQ-021 On that edge the winner's reqAddr, reqLen and wr SHALL be latched; the beat counter SHALL clear to 0.
REQ-022 Arbitration SHALL be round-robin: the winner is the first requesting index searched from (lastServed+1) mod 3 upward.
REQ-023 grant SHALL be high for the winner throughout BURST and DONE, and zero in IDLE.
REQ-024 BURST: one beat SHALL be issued per cycle, with memAddress = latchedBase + beatCnt, modulo 2^ADDR_W (silent wrap).
REQ-025 BURST: memWe SHALL equal latched wr and memRe SHALL equal its inverse; both SHALL be 0 outside BURST.
REQ-026 memWData SHALL be the live wData slice of the owner; the requester presents the data for beat k in the cycle of beat k.
REQ-027 In IDLE and DONE, memAddress and memWData SHALL be 0.
REQ-028 The beat counter SHALL increment each BURST cycle.
REQ-029 The beat with beatCnt == effLen-1 SHALL be the last, and the FSM SHALL then move to DONE.
REQ-030 effLen SHALL be reqLen, with a latched length of 0 treated as 1.
REQ-031 Read bursts: rdValid[owner] SHALL assert the cycle after each read beat, with rdData = memRData; the final rdValid SHALL fall in the DONE cycle.
REQ-032 Write bursts SHALL never assert rdValid.
REQ-033 DONE SHALL last exactly one cycle: done[owner] = 1, lastServed <= owner, next state IDLE.
REQ-034 Changes on req, reqAddr, reqLen or wr during BURST or DONE SHALL be ignored.
REQ-035 A requester still requesting in IDLE after its own done SHALL be treated as a new request.
REQ-036 Burst occupancy SHALL be effLen+2 cycles (1 IDLE arbitration cycle + effLen BURST cycles + 1 DONE cycle).

Reset
REQ-037 While rst = 0, state SHALL be IDLE, lastServed = 2 (requester 0 first), beat counter 0 and all outputs 0, independent of clk.
REQ-038 Reset asserted mid-burst SHALL abort the burst with no done pulse; after release the arbiter SHALL arbitrate afresh.

Verification
REQ-039 Single read: req=001, reqAddr0=71, reqLen0=4, wr=0 -> memAddress 71,72,73,74 with memRe=1; rdValid0 on the 4 following cycles; done0 pulse once; 6 cycles total.
REQ-040 Round-robin: req=111 held continuously, all lengths 2 -> grant order 0,1,2,0; each done pulse precedes the next grant by exactly one IDLE cycle.
REQ-041 Write burst: req=100, wr[2]=1, reqAddr2=332, reqLen2=3, wData2=A,B,C -> writes A@332, B@333, C@334; no rdValid.
REQ-042 Boundaries: reqAddr=1022 with reqLen=4 -> addresses 1022,1023,0,1. reqLen=0 -> exactly one beat.
REQ-043 Reset mid-burst: rst=0 during beat 2 of a length-5 burst -> all outputs 0 immediately; no done pulse; after release with req=010 -> grant=010 first.
REQ-044 Request churn: req0 dropped mid-burst -> burst still completes fully; req1 raised mid-burst -> served only after done0.
